hazard_scoreboard: RTL and testbench

//  Parametrised per-register scoreboard for the decode stage. Replaces ad-hoc

---
 rtl/hazard_scoreboard_if.sv | 30 +++
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake for hazard_scoreboard: issuing instruction fields in,
// stall / forward selects / pending mask out.
interface hazard_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int SEL_W = 2
);
  logic             issue_valid;
  logic [AW-1:0]    rs_addr;
  logic             rs_used;
  logic [AW-1:0]    rt_addr;
  logic             rt_used;
  logic             dst_we;
  logic [AW-1:0]    dst_addr;
  logic [1:0]       dst_class;
  logic             stall;
  logic [SEL_W-1:0] fwd_rs_sel;
  logic [SEL_W-1:0] fwd_rt_sel;
  logic [NREG-1:0]  pending;

  modport master (
    output issue_valid, rs_addr, rs_used, rt_addr, rt_used, dst_we, dst_addr, dst_class,
    input  stall, fwd_rs_sel, fwd_rt_sel, pending
  );

  modport slave (
    input  issue_valid, rs_addr, rs_used, rt_addr, rt_used, dst_we, dst_addr, dst_class,
    output stall, fwd_rs_sel, fwd_rt_sel, pending
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register age/class scoreboard driving decode stall and operand forward selects.
// Optional macro SCOREBOARD_MUL_BLOCKING_EN: MUL unit is non-pipelined (back-to-back MULs stall).
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int WB_AGE   = 3,
  parameter int SEL_W    = 2,
  parameter int LAT_ALU  = 1,
  parameter int LAT_LOAD = 2,
  parameter int LAT_MUL  = 3
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave sb
);

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_RSVD = 2'd3
  } cls_e;

  logic [SEL_W-1:0] age_q [NREG];
  logic [SEL_W-1:0] age_d [NREG];
  cls_e             cls_q [NREG];
  cls_e             cls_d [NREG];

  // Reserved class falls through to ALU latency.
  function automatic logic [SEL_W-1:0] avail_f(input cls_e c);
    case (c)
      CLS_LOAD: avail_f = SEL_W'(LAT_LOAD);
      CLS_MUL:  avail_f = SEL_W'(LAT_MUL);
      default:  avail_f = SEL_W'(LAT_ALU);
    endcase
  endfunction

  logic [SEL_W-1:0] rs_age, rt_age, rs_avail, rt_avail;
  logic             rs_nz, rt_nz, rs_hz, rt_hz;
  logic             mul_busy, record;
  logic [NREG-1:0]  pending_w;

  assign rs_nz    = (sb.rs_addr != '0);
  assign rt_nz    = (sb.rt_addr != '0);
  assign rs_age   = age_q[sb.rs_addr];
  assign rt_age   = age_q[sb.rt_addr];
  assign rs_avail = avail_f(cls_q[sb.rs_addr]);
  assign rt_avail = avail_f(cls_q[sb.rt_addr]);
  assign rs_hz    = rs_nz && (rs_age != '0) && (rs_age < rs_avail);
  assign rt_hz    = rt_nz && (rt_age != '0) && (rt_age < rt_avail);

  assign sb.stall      = !rst && sb.issue_valid &&
                         ((sb.rs_used && rs_hz) || (sb.rt_used && rt_hz) || mul_busy);
  assign sb.fwd_rs_sel = (!rst && rs_nz && (rs_age >= rs_avail)) ? rs_age : '0;
  assign sb.fwd_rt_sel = (!rst && rt_nz && (rt_age >= rt_avail)) ? rt_age : '0;

  assign record = sb.issue_valid && !sb.stall && sb.dst_we && (sb.dst_addr != '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) pending_w[r] = (age_q[r] != '0);
  end
  assign sb.pending = pending_w;

  // NOTE: every next-state variable gets a default before any condition, so no latch can be inferred.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      age_d[r] = '0;
      cls_d[r] = cls_q[r];
      if ((age_q[r] != '0) && (age_q[r] < SEL_W'(WB_AGE))) age_d[r] = age_q[r] + SEL_W'(1);
    end
    // A new producer overrides aging, so the youngest writer of a register wins.
    if (record) begin
      age_d[sb.dst_addr] = SEL_W'(1);
      cls_d[sb.dst_addr] = cls_e'(sb.dst_class);
    end
  end

  // NOTE: the per-register arrays are reset explicitly; a reset must discard every in-flight entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        age_q[r] <= '0;
        cls_q[r] <= CLS_ALU;
      end
    end else begin
      age_q <= age_d;
      cls_q <= cls_d;
    end
  end

`ifdef SCOREBOARD_MUL_BLOCKING_EN
  logic [SEL_W-1:0] mul_cnt_q, mul_cnt_d;
  logic             mul_inflight, mul_issue;

  always_comb begin
    mul_inflight = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if ((cls_q[r] == CLS_MUL) && (age_q[r] != '0) && (age_q[r] < SEL_W'(LAT_MUL)))
        mul_inflight = 1'b1;
    end
  end

  // Hidden occupancy counter also covers MULs whose destination is register 0.
  assign mul_issue = sb.issue_valid && !sb.stall && (cls_e'(sb.dst_class) == CLS_MUL);

  always_comb begin
    mul_cnt_d = '0;
    if (mul_issue) mul_cnt_d = SEL_W'(1);
    else if ((mul_cnt_q != '0) && (mul_cnt_q < SEL_W'(LAT_MUL))) mul_cnt_d = mul_cnt_q + SEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) mul_cnt_q <= '0;
    else     mul_cnt_q <= mul_cnt_d;
  end

  assign mul_busy = sb.issue_valid && (cls_e'(sb.dst_class) == CLS_MUL) &&
                    (mul_inflight || ((mul_cnt_q != '0) && (mul_cnt_q < SEL_W'(LAT_MUL))));
`else
  assign mul_busy = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// checked against a producer-history model (issue cycle per register).
module tb_hazard_scoreboard;
  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int WB_AGE   = 3;
  localparam int SEL_W    = 2;
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 3;
  localparam int NONE     = -100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .SEL_W(SEL_W)) bus ();

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .WB_AGE(WB_AGE), .SEL_W(SEL_W),
    .LAT_ALU(LAT_ALU), .LAT_LOAD(LAT_LOAD), .LAT_MUL(LAT_MUL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: cycle number of the latest recorded write per register.
  int cyc = 0;
  int last_iss [NREG];
  int last_cls [NREG];
  int last_mul;

  logic             obs_stall;
  logic [SEL_W-1:0] obs_rs, obs_rt;
  logic [NREG-1:0]  obs_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int m_age(input int r);
    int d;
    if (r == 0) return 0;
    d = cyc - last_iss[r];
    return (d >= 1 && d <= WB_AGE) ? d : 0;
  endfunction

  function automatic int m_lat(input int c);
    return (c == 1) ? LAT_LOAD : (c == 2) ? LAT_MUL : LAT_ALU;
  endfunction

  function automatic int m_sel(input int r);
    int a;
    a = m_age(r);
    return (a != 0 && a >= m_lat(last_cls[r])) ? a : 0;
  endfunction

  function automatic bit m_hz(input int r);
    int a;
    a = m_age(r);
    return (a != 0) && (a < m_lat(last_cls[r]));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      last_iss[i] = NONE;
      last_cls[i] = 0;
    end
    last_mul = NONE;
  endtask

  // One decode cycle: drive, compare combinational outputs, clock, update model.
  task automatic step(input bit r, input bit iv, input int rs, input bit rsu,
                      input int rt, input bit rtu, input bit we, input int dst, input int cl);
    bit              e_stall, mb;
    int              e_rs, e_rt;
    logic [NREG-1:0] e_pend;
    rst             = r;
    bus.issue_valid = iv;
    bus.rs_addr     = AW'(rs);
    bus.rs_used     = rsu;
    bus.rt_addr     = AW'(rt);
    bus.rt_used     = rtu;
    bus.dst_we      = we;
    bus.dst_addr    = AW'(dst);
    bus.dst_class   = 2'(cl);
    #1;
    mb = 1'b0;
`ifdef SCOREBOARD_MUL_BLOCKING_EN
    if (iv && cl == 2 && (cyc - last_mul) >= 1 && (cyc - last_mul) < LAT_MUL) mb = 1'b1;
`endif
    e_stall = !r && iv && ((rsu && m_hz(rs)) || (rtu && m_hz(rt)) || mb);
    e_rs    = r ? 0 : m_sel(rs);
    e_rt    = r ? 0 : m_sel(rt);
    for (int i = 0; i < NREG; i++) e_pend[i] = (m_age(i) != 0);
    obs_stall = bus.stall;
    obs_rs    = bus.fwd_rs_sel;
    obs_rt    = bus.fwd_rt_sel;
    obs_pend  = bus.pending;
    check("stall", 32'(obs_stall), 32'(e_stall));
    check("fwd_rs_sel", 32'(obs_rs), 32'(e_rs));
    check("fwd_rt_sel", 32'(obs_rt), 32'(e_rt));
    if (!r) check("pending", 32'(obs_pend), 32'(e_pend));
    @(posedge clk);
    if (r) model_clear();
    else if (iv && !e_stall) begin
      if (we && dst != 0) begin
        last_iss[dst] = cyc;
        last_cls[dst] = cl;
      end
      if (cl == 2) last_mul = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 3, 1'b1, 4, 1'b1, 1'b1, 5, 0);
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    check("reset_pending", 32'(obs_pend), 32'd0);

    // ALU $3 then four reads of $3: selects walk EX, MEM, WB, regfile.
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 3, 0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 0, 0);
      check("alu_rs_sel", 32'(obs_rs), (k == 4) ? 32'd0 : 32'(k));
      check("alu_stall", 32'(obs_stall), 32'd0);
    end
    idle(4);

    // LOAD $5 then read rt=$5.
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5, 1);
    step(1'b0, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 0, 0);
    check("load_stall_c1", 32'(obs_stall), 32'd1);
    step(1'b0, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 0, 0);
    check("load_stall_c2", 32'(obs_stall), 32'd0);
    check("load_rt_sel_c2", 32'(obs_rt), 32'd2);
    idle(4);

    // MUL $7 then reads of $7.
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 7, 2);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 7, 1'b1, 0, 1'b0, 1'b0, 0, 0);
      check("mul_stall", 32'(obs_stall), (k < 3) ? 32'd1 : 32'd0);
      check("mul_rs_sel", 32'(obs_rs), (k == 3) ? 32'd3 : 32'd0);
    end
    idle(4);

    // Writes to $0 are never tracked.
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    check("r0_pending", 32'(obs_pend), 32'd0);
    check("r0_stall", 32'(obs_stall), 32'd0);
    check("r0_sel", 32'(obs_rs), 32'd0);
    idle(4);

    // WAW: younger ALU write of $4 overrides older LOAD.
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 4, 1);
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 4, 0);
    step(1'b0, 1'b1, 4, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    check("waw_stall", 32'(obs_stall), 32'd0);
    check("waw_sel", 32'(obs_rs), 32'd1);
    idle(4);

    // Reset mid-flight discards the LOAD $9.
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 9, 1);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 9, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    check("rst_pending", 32'(obs_pend), 32'd0);
    check("rst_stall", 32'(obs_stall), 32'd0);
    check("rst_sel", 32'(obs_rs), 32'd0);
    idle(4);

    // Back-to-back MULs.
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 2, 2);
`ifdef SCOREBOARD_MUL_BLOCKING_EN
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 6, 2);
      check("mul_b2b_stall", 32'(obs_stall), (k < 3) ? 32'd1 : 32'd0);
    end
`else
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 6, 2);
    check("mul_b2b_stall", 32'(obs_stall), 32'd0);
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 8, 2);
    check("mul_b2b_stall", 32'(obs_stall), 32'd0);
`endif
    idle(4);

    // Random traffic on a small register window so hazards are frequent.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
